// File: rtl/que_slot_transmit_handler.sv
// Queue-slot transmit handler.
// Drains one slot FIFO (9-bit entries: bit 8 = first-byte flag, bits 7:0 = data),
// wins the egress arbiter and streams one frame to the MAC over valid/ready.
// The end of a frame is found by lookahead: a byte is only presented once its
// successor is visible (or the FIFO has stayed empty for TIMEOUT_LIMIT cycles),
// so tx_last can be registered together with the byte itself.
module que_slot_transmit_handler #(
    parameter logic [15:0] TIMEOUT_LIMIT   = 16'd8,
    parameter logic [15:0] MAX_FRAME_BYTES = 16'd1518
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [8:0]  fifo_data,
    input  logic        fifo_empty,
    output logic        fifo_read_enable,
    output logic        request,
    input  logic        grant,
    output logic [7:0]  tx_data,
    output logic        tx_data_valid,
    output logic        tx_last,
    input  logic        tx_data_ready,
    output logic        frame_done,
    output logic [15:0] frame_length,
    output logic        orphan_drop,
    output logic        truncated
);

    typedef enum logic [2:0] {
        StIdle,
        StRequest,
        StFetch,
        StPresent,
        StFlush
    } state_e;

    state_e      state_q;
    logic [7:0]  hold_data_q;
    logic [15:0] byte_count_q;
    logic [15:0] timeout_count_q;
    // Set when the frame is being cut at MAX_FRAME_BYTES; consumed on the last accept.
    logic        trunc_mark_q;

    logic        head_valid;
    logic        head_first;
    logic        accept;
    logic [15:0] byte_count_inc;
    logic [15:0] timeout_inc;
    logic        timeout_hit;

    // Decoded head/handshake conditions and saturating counter increments.
    always_comb begin
        head_valid     = !fifo_empty;
        head_first     = fifo_data[8];
        accept         = tx_data_valid && tx_data_ready;
        byte_count_inc = (byte_count_q >= MAX_FRAME_BYTES) ? MAX_FRAME_BYTES
                                                           : byte_count_q + 16'd1;
        timeout_inc    = (timeout_count_q >= TIMEOUT_LIMIT) ? TIMEOUT_LIMIT
                                                            : timeout_count_q + 16'd1;
        timeout_hit    = (timeout_inc >= TIMEOUT_LIMIT);
    end

    // Pop strobe: combinational so a pop lands in the same cycle as the decision.
    always_comb begin
        fifo_read_enable = 1'b0;
        if (!reset && head_valid) begin
            case (state_q)
                StIdle:    fifo_read_enable = !head_first;
                StRequest: fifo_read_enable = grant;
                StPresent: fifo_read_enable = accept && !tx_last;
                StFlush:   fifo_read_enable = !head_first;
                default:   fifo_read_enable = 1'b0;
            endcase
        end
    end

    // Frame FSM with all outputs registered.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q         <= StIdle;
            hold_data_q     <= 8'd0;
            byte_count_q    <= 16'd0;
            timeout_count_q <= 16'd0;
            trunc_mark_q    <= 1'b0;
            request         <= 1'b0;
            tx_data         <= 8'd0;
            tx_data_valid   <= 1'b0;
            tx_last         <= 1'b0;
            frame_done      <= 1'b0;
            frame_length    <= 16'd0;
            orphan_drop     <= 1'b0;
            truncated       <= 1'b0;
        end else begin
            frame_done  <= 1'b0;
            orphan_drop <= 1'b0;
            truncated   <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (head_valid) begin
                        if (head_first) begin
                            state_q <= StRequest;
                            request <= 1'b1;
                        end else begin
                            // Continuation byte with no frame open: discard it.
                            orphan_drop <= 1'b1;
                        end
                    end
                end

                StRequest: begin
                    if (grant && head_valid) begin
                        hold_data_q     <= fifo_data[7:0];
                        byte_count_q    <= 16'd1;
                        timeout_count_q <= 16'd0;
                        trunc_mark_q    <= 1'b0;
                        state_q         <= StFetch;
                    end
                end

                StFetch: begin
                    if (head_valid) begin
                        // A visible head wins over a timeout expiring in the same cycle.
                        tx_data       <= hold_data_q;
                        tx_data_valid <= 1'b1;
                        state_q       <= StPresent;
                        if (head_first) begin
                            tx_last <= 1'b1;
                        end else if (byte_count_q < MAX_FRAME_BYTES) begin
                            tx_last <= 1'b0;
                        end else begin
                            tx_last      <= 1'b1;
                            trunc_mark_q <= 1'b1;
                        end
                    end else begin
                        timeout_count_q <= timeout_inc;
                        if (timeout_hit) begin
                            tx_data       <= hold_data_q;
                            tx_data_valid <= 1'b1;
                            tx_last       <= 1'b1;
                            state_q       <= StPresent;
                        end
                    end
                end

                StPresent: begin
                    if (accept) begin
                        tx_data_valid <= 1'b0;
                        tx_last       <= 1'b0;
                        if (!tx_last) begin
                            // Successor was seen in StFetch; it is popped right now.
                            hold_data_q     <= fifo_data[7:0];
                            byte_count_q    <= byte_count_inc;
                            timeout_count_q <= 16'd0;
                            state_q         <= StFetch;
                        end else begin
                            frame_done      <= 1'b1;
                            frame_length    <= byte_count_q;
                            request         <= 1'b0;
                            timeout_count_q <= 16'd0;
                            if (trunc_mark_q) begin
                                truncated    <= 1'b1;
                                trunc_mark_q <= 1'b0;
                                state_q      <= StFlush;
                            end else begin
                                state_q <= StIdle;
                            end
                        end
                    end
                end

                StFlush: begin
                    if (head_valid) begin
                        if (head_first) begin
                            // Next frame starts here; leave it in the FIFO.
                            state_q <= StIdle;
                        end else begin
                            timeout_count_q <= 16'd0;
                        end
                    end else begin
                        timeout_count_q <= timeout_inc;
                        if (timeout_hit) begin
                            state_q <= StIdle;
                        end
                    end
                end

                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_que_slot_transmit_handler.sv
// Directed bench for que_slot_transmit_handler (MAX_FRAME_BYTES overridden to 4).
module tb_que_slot_transmit_handler;

    logic        clock = 1'b0;
    logic        reset;
    logic [8:0]  fifo_data;
    logic        fifo_empty;
    logic        fifo_read_enable;
    logic        request;
    logic        grant = 1'b0;
    logic [7:0]  tx_data;
    logic        tx_data_valid;
    logic        tx_last;
    logic        tx_data_ready;
    logic        frame_done;
    logic [15:0] frame_length;
    logic        orphan_drop;
    logic        truncated;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    que_slot_transmit_handler #(
        .TIMEOUT_LIMIT  (16'd8),
        .MAX_FRAME_BYTES(16'd4)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .fifo_data       (fifo_data),
        .fifo_empty      (fifo_empty),
        .fifo_read_enable(fifo_read_enable),
        .request         (request),
        .grant           (grant),
        .tx_data         (tx_data),
        .tx_data_valid   (tx_data_valid),
        .tx_last         (tx_last),
        .tx_data_ready   (tx_data_ready),
        .frame_done      (frame_done),
        .frame_length    (frame_length),
        .orphan_drop     (orphan_drop),
        .truncated       (truncated)
    );

    always #5 clock = ~clock;

    // FWFT FIFO model: pushes from the stimulus, pops on the DUT strobe.
    logic [8:0] fifo_mem [0:255];
    logic [7:0] wr = 8'd0;
    logic [7:0] rd = 8'd0;
    assign fifo_empty = (rd == wr);
    assign fifo_data  = fifo_empty ? 9'h000 : fifo_mem[rd];

    always @(posedge clock) begin
        cyc <= cyc + 1;
        if (!reset && fifo_read_enable && !fifo_empty) rd <= rd + 8'd1;
    end

    // Arbiter model: grant grant_delay cycles after request, held while requested.
    int grant_delay = 2;
    int gcnt = 0;
    always @(posedge clock) begin
        if (!request) begin
            grant <= 1'b0;
            gcnt  <= 0;
        end else if (!grant) begin
            if (gcnt + 1 >= grant_delay) grant <= 1'b1;
            else gcnt <= gcnt + 1;
        end
    end

    // Event log, sampled mid-cycle.
    logic [8:0]  acc_word [0:63];
    int          acc_cyc  [0:63];
    logic [15:0] fd_len   [0:63];
    int n_acc = 0, n_fd = 0, n_orph = 0, n_trunc = 0, n_req_rise = 0;
    int last_fd_cyc = 0, last_tr_cyc = 0;
    logic req_prev = 1'b0;
    logic pop_empty_seen = 1'b0;
    logic orph_req_seen = 1'b0;

    always @(negedge clock) begin
        if (!reset) begin
            if (tx_data_valid && tx_data_ready) begin
                acc_word[n_acc] <= {tx_last, tx_data};
                acc_cyc[n_acc]  <= cyc;
                n_acc           <= n_acc + 1;
            end
            if (frame_done) begin
                fd_len[n_fd] <= frame_length;
                n_fd         <= n_fd + 1;
                last_fd_cyc  <= cyc;
            end
            if (orphan_drop) n_orph <= n_orph + 1;
            if (orphan_drop && request) orph_req_seen <= 1'b1;
            if (truncated) begin
                n_trunc     <= n_trunc + 1;
                last_tr_cyc <= cyc;
            end
            if (request && !req_prev) n_req_rise <= n_req_rise + 1;
            if (fifo_read_enable && fifo_empty) pop_empty_seen <= 1'b1;
        end
        req_prev <= request;
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic push(input logic [8:0] v);
        fifo_mem[wr] = v;
        wr = wr + 8'd1;
    endtask

    task automatic wait_frames(input int target, input int budget, input string name);
        int n;
        n = 0;
        while (n_fd < target && n < budget) begin
            step(1);
            n++;
        end
        total++;
        if (n_fd < target) begin
            bad++;
            $display("FAIL %s_wait: frames seen %0d, required %0d", name, n_fd, target);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tx_data_ready = 1'b1;
        step(3);
        total++;
        if ({request, tx_data_valid, tx_last, frame_done, orphan_drop, truncated,
             fifo_read_enable} !== 7'b0) begin
            bad++;
            $display("FAIL reset_ctrl: got %b required 0000000", {request, tx_data_valid,
                     tx_last, frame_done, orphan_drop, truncated, fifo_read_enable});
        end
        total++;
        if (tx_data !== 8'h00) begin
            bad++;
            $display("FAIL reset_tx_data: got %h required 00", tx_data);
        end
        total++;
        if (frame_length !== 16'd0) begin
            bad++;
            $display("FAIL reset_frame_length: got %0d required 0", frame_length);
        end
        reset = 1'b0;
        step(2);
    endtask

    task automatic test_single_frame();
        logic [8:0] exp_w [4];
        int b, bf, n, g, v;
        exp_w = '{9'h0A5, 9'h022, 9'h033, 9'h144};
        b = n_acc;
        bf = n_fd;
        grant_delay = 2;
        push(9'h1A5); push(9'h022); push(9'h033); push(9'h044);
        n = 0;
        while (!(request && grant) && n < 50) begin step(1); n++; end
        g = cyc;
        while (!tx_data_valid && n < 50) begin step(1); n++; end
        v = cyc;
        total++;
        if (v - g != 2) begin
            bad++;
            $display("FAIL single_latency: grant->valid %0d cycles, required 2", v - g);
        end
        wait_frames(bf + 1, 100, "single");
        step(2);
        total++;
        if (n_acc - b != 4) begin
            bad++;
            $display("FAIL single_count: got %0d bytes, required 4", n_acc - b);
        end
        for (int i = 0; i < 4; i++) begin
            total++;
            if (acc_word[b + i] !== exp_w[i]) begin
                bad++;
                $display("FAIL single_byte%0d: got {last,data}=%h required %h", i,
                         acc_word[b + i], exp_w[i]);
            end
        end
        total++;
        if (acc_cyc[b + 2] - acc_cyc[b + 1] != 2) begin
            bad++;
            $display("FAIL single_pace: got %0d cycles, required 2",
                     acc_cyc[b + 2] - acc_cyc[b + 1]);
        end
        // 33 popped 44 and left the FIFO empty: 8 empty fetch cycles, then present.
        total++;
        if (acc_cyc[b + 3] - acc_cyc[b + 2] != 9) begin
            bad++;
            $display("FAIL single_timeout: got %0d cycles, required 9",
                     acc_cyc[b + 3] - acc_cyc[b + 2]);
        end
        total++;
        if (n_fd - bf != 1 || fd_len[bf] !== 16'd4) begin
            bad++;
            $display("FAIL single_done: got %0d pulses len %0d, required 1 len 4",
                     n_fd - bf, fd_len[bf]);
        end
    endtask

    task automatic test_back_to_back();
        logic [8:0] exp_w [4];
        int b, bf, br;
        exp_w = '{9'h001, 9'h102, 9'h003, 9'h104};
        b = n_acc;
        bf = n_fd;
        br = n_req_rise;
        push(9'h101); push(9'h002); push(9'h103); push(9'h004);
        wait_frames(bf + 2, 200, "b2b");
        step(2);
        total++;
        if (n_acc - b != 4) begin
            bad++;
            $display("FAIL b2b_count: got %0d bytes, required 4", n_acc - b);
        end
        for (int i = 0; i < 4; i++) begin
            total++;
            if (acc_word[b + i] !== exp_w[i]) begin
                bad++;
                $display("FAIL b2b_byte%0d: got {last,data}=%h required %h", i,
                         acc_word[b + i], exp_w[i]);
            end
        end
        total++;
        if (acc_cyc[b + 1] - acc_cyc[b] != 2) begin
            bad++;
            $display("FAIL b2b_no_wait: got %0d cycles, required 2",
                     acc_cyc[b + 1] - acc_cyc[b]);
        end
        total++;
        if (fd_len[bf] !== 16'd2 || fd_len[bf + 1] !== 16'd2) begin
            bad++;
            $display("FAIL b2b_lengths: got %0d,%0d required 2,2", fd_len[bf], fd_len[bf + 1]);
        end
        total++;
        if (n_req_rise - br != 2) begin
            bad++;
            $display("FAIL b2b_requests: got %0d request rises, required 2", n_req_rise - br);
        end
    endtask

    task automatic test_stall();
        logic [8:0] exp_w [4];
        int b, bf, n;
        logic stable, popped;
        exp_w = '{9'h0A5, 9'h022, 9'h033, 9'h144};
        b = n_acc;
        bf = n_fd;
        push(9'h1A5); push(9'h022); push(9'h033); push(9'h044);
        n = 0;
        while (!(tx_data_valid && tx_data == 8'h22) && n < 100) begin step(1); n++; end
        tx_data_ready = 1'b0;
        stable = 1'b1;
        popped = 1'b0;
        repeat (5) begin
            step(1);
            if (!(tx_data_valid && tx_data == 8'h22 && !tx_last)) stable = 1'b0;
            if (fifo_read_enable) popped = 1'b1;
        end
        total++;
        if (stable !== 1'b1) begin
            bad++;
            $display("FAIL stall_stable: got valid=%b data=%h last=%b required 1/22/0",
                     tx_data_valid, tx_data, tx_last);
        end
        total++;
        if (popped !== 1'b0) begin
            bad++;
            $display("FAIL stall_no_pop: got fifo_read_enable=1 while stalled, required 0");
        end
        tx_data_ready = 1'b1;
        wait_frames(bf + 1, 100, "stall");
        step(2);
        total++;
        if (n_acc - b != 4) begin
            bad++;
            $display("FAIL stall_count: got %0d bytes, required 4", n_acc - b);
        end
        for (int i = 0; i < 4; i++) begin
            total++;
            if (acc_word[b + i] !== exp_w[i]) begin
                bad++;
                $display("FAIL stall_byte%0d: got {last,data}=%h required %h", i,
                         acc_word[b + i], exp_w[i]);
            end
        end
    endtask

    task automatic test_orphan();
        int b, bf, bo, br;
        b = n_acc;
        bf = n_fd;
        bo = n_orph;
        br = n_req_rise;
        push(9'h055); push(9'h166);
        wait_frames(bf + 1, 100, "orphan");
        step(2);
        total++;
        if (n_orph - bo != 1) begin
            bad++;
            $display("FAIL orphan_pulses: got %0d, required 1", n_orph - bo);
        end
        total++;
        if (orph_req_seen !== 1'b0) begin
            bad++;
            $display("FAIL orphan_request: got request=1 during orphan drop, required 0");
        end
        total++;
        if (n_req_rise - br != 1) begin
            bad++;
            $display("FAIL orphan_requests: got %0d request rises, required 1", n_req_rise - br);
        end
        total++;
        if (n_acc - b != 1 || acc_word[b] !== 9'h166 || fd_len[bf] !== 16'd1) begin
            bad++;
            $display("FAIL orphan_frame: got %0d bytes first=%h len %0d, required 1/166/1",
                     n_acc - b, acc_word[b], fd_len[bf]);
        end
    endtask

    task automatic test_truncate();
        logic [8:0] exp_w [5];
        int b, bf, bo, bt;
        exp_w = '{9'h010, 9'h011, 9'h012, 9'h113, 9'h177};
        b = n_acc;
        bf = n_fd;
        bo = n_orph;
        bt = n_trunc;
        push(9'h110); push(9'h011); push(9'h012); push(9'h013);
        push(9'h014); push(9'h015); push(9'h177);
        wait_frames(bf + 2, 200, "trunc");
        step(2);
        total++;
        if (n_acc - b != 5) begin
            bad++;
            $display("FAIL trunc_count: got %0d bytes, required 5", n_acc - b);
        end
        for (int i = 0; i < 5; i++) begin
            total++;
            if (acc_word[b + i] !== exp_w[i]) begin
                bad++;
                $display("FAIL trunc_byte%0d: got {last,data}=%h required %h", i,
                         acc_word[b + i], exp_w[i]);
            end
        end
        total++;
        if (n_trunc - bt != 1 || last_tr_cyc != last_fd_cyc - 0 && n_fd - bf != 2) begin
            bad++;
            $display("FAIL trunc_pulse: got %0d pulses, required 1", n_trunc - bt);
        end
        total++;
        if (fd_len[bf] !== 16'd4 || fd_len[bf + 1] !== 16'd1) begin
            bad++;
            $display("FAIL trunc_lengths: got %0d,%0d required 4,1", fd_len[bf], fd_len[bf + 1]);
        end
        total++;
        if (n_orph != bo || rd != wr) begin
            bad++;
            $display("FAIL trunc_flush: got orphans +%0d fifo_empty=%b, required +0 and 1",
                     n_orph - bo, fifo_empty);
        end
    endtask

    task automatic test_reset_midframe();
        int b, bf, bo, n;
        b = n_acc;
        bf = n_fd;
        bo = n_orph;
        push(9'h1AA); push(9'h0BB); push(9'h0CC); push(9'h0DD);
        n = 0;
        while (!(tx_data_valid && tx_data == 8'hBB) && n < 100) begin step(1); n++; end
        tx_data_ready = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        total++;
        if ({request, tx_data_valid, tx_last, frame_done, orphan_drop, truncated,
             fifo_read_enable} !== 7'b0 || tx_data !== 8'h00) begin
            bad++;
            $display("FAIL midreset_outputs: got ctrl=%b data=%h, required 0000000/00",
                     {request, tx_data_valid, tx_last, frame_done, orphan_drop, truncated,
                      fifo_read_enable}, tx_data);
        end
        total++;
        if (frame_length !== 16'd0) begin
            bad++;
            $display("FAIL midreset_length: got %0d required 0", frame_length);
        end
        step(2);
        #2;
        reset = 1'b0;
        tx_data_ready = 1'b1;
        step(20);
        total++;
        if (n_orph - bo != 2 || rd != wr) begin
            bad++;
            $display("FAIL midreset_orphans: got %0d drops fifo_empty=%b, required 2 and 1",
                     n_orph - bo, fifo_empty);
        end
        total++;
        if (n_acc - b != 1 || n_fd != bf || request !== 1'b0) begin
            bad++;
            $display("FAIL midreset_abandon: got bytes %0d frames %0d request %b, required 1/0/0",
                     n_acc - b, n_fd - bf, request);
        end
    endtask

    task automatic test_fifo_protocol();
        total++;
        if (pop_empty_seen !== 1'b0) begin
            bad++;
            $display("FAIL pop_when_empty: got fifo_read_enable=1 with fifo_empty=1, required 0");
        end
    endtask

    initial begin
        reset = 1'b1;
        tx_data_ready = 1'b1;
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_stall();
        test_orphan();
        test_truncate();
        test_reset_midframe();
        test_fifo_protocol();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/que_slot_transmit_handler.md
Name: que_slot_transmit_handler

Overview:
- Drains one queue-slot FIFO. Each entry is 9 bits: bit 8 is the first-byte flag and bits 7:0 are the data byte.
- Requests the egress arbiter and, once granted, streams one frame to the egress MAC over a valid/ready byte interface.
- Finds the frame end by lookahead: the next entry has bit 8 set, or the FIFO stays empty for a timeout.
- Discards orphan bytes and truncates oversize frames. Sits between the slot FIFO read port and the egress port arbiter/MAC.

Parameters:
- TIMEOUT_LIMIT, 16'd8: consecutive FIFO-empty cycles in S_FETCH that close the frame.
- MAX_FRAME_BYTES, 16'd1518: maximum bytes emitted per frame. Must be ≥1.

Ports:
- clock  input  1  single clock
- reset  input  1  asynchronous, active-high reset
- fifo_data  input  9  FWFT head entry; valid when fifo_empty=0
- fifo_empty  input  1  slot FIFO empty
- fifo_read_enable  output  1  pop strobe; combinational, never asserted while fifo_empty=1
- request  output  1  arbiter request; high from S_REQUEST through end of frame
- grant  input  1  arbiter grant; sampled only in S_REQUEST; arbiter holds it while request=1
- tx_data  output  8  egress byte
- tx_data_valid  output  1  egress byte valid
- tx_last  output  1  final byte of frame; qualified by tx_data_valid
- tx_data_ready  input  1  MAC accepts; a transfer occurs when valid && ready
- frame_done  output  1  one-cycle pulse after the last byte is accepted
- frame_length  output  16  bytes emitted in the last frame; updated with frame_done
- orphan_drop  output  1  one-cycle pulse per orphan entry discarded
- truncated  output  1  one-cycle pulse when a frame is cut at MAX_FRAME_BYTES

Behaviour:
- Reset: asynchronous, immediate. All registered outputs are 0, the state is S_IDLE, and the counters are 0. fifo_read_enable goes 0 combinationally. FIFO contents are untouched; a frame in flight is abandoned.
- Registers: hold_data[7:0], byte_count[15:0], timeout_count[15:0].
- S_IDLE, FIFO not empty:
  - Head bit 8 = 0: pop it and pulse orphan_drop next cycle. One pop per cycle, stay in S_IDLE.
  - Head bit 8 = 1: go to S_REQUEST.
- S_REQUEST: request=1. When grant=1, pop the head into hold_data, set byte_count=1, clear timeout_count, go to S_FETCH.
- S_FETCH (lookahead decision):
  - FIFO not empty, head bit 8 = 0, byte_count < MAX_FRAME_BYTES: register tx_data=hold_data, tx_data_valid=1, tx_last=0. Go to S_PRESENT.
  - FIFO not empty, head bit 8 = 1: present with tx_last=1.
  - byte_count = MAX_FRAME_BYTES and next head is a continuation byte (bit 8 = 0): present with tx_last=1 and mark truncate.
  - FIFO empty: increment timeout_count. When it reaches TIMEOUT_LIMIT, present with tx_last=1.
- S_PRESENT:
  - tx_data, tx_data_valid and tx_last hold stable until tx_data_ready=1. No pops while stalled.
  - On accept with tx_last=0: pop the head into hold_data, byte_count+1, clear timeout_count, deassert tx_data_valid, go to S_FETCH.
  - On accept with tx_last=1: deassert valid and last, pulse frame_done, load frame_length=byte_count.
    - If a truncate is marked: pulse truncated, go to S_FLUSH.
    - Otherwise: go to S_IDLE.
  - request drops in the cycle after the accept.
- S_FLUSH: pop each head with bit 8 = 0. Exit to S_IDLE on a head with bit 8 = 1 (not popped) or after TIMEOUT_LIMIT empty cycles.
- Throughput: one byte per two clocks, since each byte needs a visible successor. Core clock ≥ 2× line byte rate.
- Latency: grant at cycle N → first tx_data_valid at N+2 when the successor is already present.
- Arithmetic: byte_count saturates at MAX_FRAME_BYTES. timeout_count saturates at TIMEOUT_LIMIT.
- Simultaneous events: in S_FETCH, a head arriving in the same cycle the timeout would expire takes priority over the timeout. grant outside S_REQUEST is ignored.

Test Plan:
- FIFO {1A5,022,033,044}, grant 2 cycles after request → bytes A5,22,33,44; tx_last on 44 exactly 8 empty cycles into S_FETCH; frame_done with frame_length=4.
- FIFO {101,002,103,004} → frame 01,02 with last on 02 and no timeout wait; request drops, then rises again; frame 03,04; two frame_done pulses with length 2 each.
- tx_data_ready low for 5 cycles while byte 22 is presented → tx_data=22 and tx_last=0 stay stable; fifo_read_enable stays 0; the stream resumes intact.
- Head 055 then 166 in S_IDLE → 055 popped with one orphan_drop pulse; request rises only for the 166 frame.
- MAX_FRAME_BYTES=4, frame {110,011,012,013,014,015} → bytes 10..13 with last on 13; truncated and frame_done pulse with length 4; 14 and 15 flushed; return to S_IDLE.
- reset asserted while byte 2 is presented → all outputs 0 in the same cycle with no clock edge needed; after release the block is in S_IDLE and orphan-drops the remaining bit 8 = 0 entries.
